// File: rtl/mips_control_unit.sv
// -----------------------------------------------------------------------------
// mips_control_unit
//
// Main decoder for the single-issue MIPS-subset datapath. The 6-bit opcode is
// decoded combinationally into the datapath control word. The word is then
// registered, so it is valid one cycle after the opcode is presented and lines
// up with the next pipeline stage.
//
// The hazard logic can hold the registered word (Stall) or replace it with an
// all-zero bubble (Flush). At each rising edge, Reset beats Flush, Flush beats
// Stall, and Stall beats the normal decode load.
//
// Optional feature (macro CTRL_ILLEGAL_OP_EN):
//   When defined, the design adds the registered output IllegalOp. It is 1 when
//   the latched opcode is not in the decode table. Reset and Flush clear it,
//   and Stall holds it. When the macro is undefined, the port does not exist
//   and undefined opcodes decode as a NOP.
//
// Ports:
//   Clk        in   1  rising-edge clock
//   Reset      in   1  asynchronous, active-high; clears all registered outputs
//   Opcode     in   6  instruction bits [31:26]
//   Stall      in   1  hold all outputs at their current values
//   Flush      in   1  load the all-zero bubble on the next edge
//   RegDst     out  2  00 = rt, 01 = rd, 10 = $31
//   ALUSrc     out  1  0 = register operand, 1 = sign-extended immediate
//   MemtoReg   out  2  00 = ALU result, 01 = memory data, 10 = PC+4
//   RegWrite   out  1  register file write enable
//   MemRead    out  1  data memory read enable
//   MemWrite   out  1  data memory write enable
//   Branch     out  1  conditional branch (beq)
//   Jump       out  1  unconditional jump
//   ALUOp      out  2  00 = add, 01 = subtract, 10 = use funct field
//   IllegalOp  out  1  undefined opcode latched (CTRL_ILLEGAL_OP_EN only)
// -----------------------------------------------------------------------------
module mips_control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Stall,
  input  logic       Flush,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic [1:0] ALUOp
`ifdef CTRL_ILLEGAL_OP_EN
  ,
  output logic       IllegalOp
`endif
);

  // Opcodes recognised by the decoder.
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_SUBI  = 6'b001010,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  // Field encodings.
  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Control word, with fields in the order of the output ports.
  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  // The bubble is the all-zero word: it writes nothing and does not branch.
  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  illegal_d;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default value first. As a result, no
  // path through the case statement leaves a signal unassigned, and no latch
  // is inferred.
  always_comb begin
    ctrl_d    = CTRL_NOP;
    illegal_d = 1'b0;
    case (opcode_e'(Opcode))
      OP_RTYPE: begin
        ctrl_d.reg_dst   = DST_RD;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.reg_dst    = DST_RA;
        ctrl_d.mem_to_reg = WB_PC4;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_SUBI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_SUB;
      end
      OP_LW: begin
        ctrl_d.reg_dst    = DST_RT;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = WB_MEM;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      default: begin
        // An undefined opcode stays a NOP, so it can never write the register
        // file or memory.
        illegal_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register: Reset > Flush > Stall > load
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments. All registers
  // therefore sample their inputs before any of them change, and the update
  // order within the block does not matter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ctrl_q <= CTRL_NOP;
    end else if (Flush) begin
      ctrl_q <= CTRL_NOP;
    end else if (!Stall) begin
      ctrl_q <= ctrl_d;
    end
  end

`ifdef CTRL_ILLEGAL_OP_EN
  logic illegal_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      illegal_q <= 1'b0;
    end else if (Flush) begin
      illegal_q <= 1'b0;
    end else if (!Stall) begin
      illegal_q <= illegal_d;
    end
  end

  assign IllegalOp = illegal_q;
`else
  // Without the feature, the illegal-opcode flag has no consumer.
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

  assign RegDst   = ctrl_q.reg_dst;
  assign ALUSrc   = ctrl_q.alu_src;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign Jump     = ctrl_q.jump;
  assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_mips_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_control_unit
//
// Directed testbench for mips_control_unit. Each step drives an opcode with
// Stall and Flush. At the same time, it pushes the expected control word, taken
// from the bench's own decode table, into a scoreboard queue. One edge later,
// it pops that word and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mips_control_unit;

`ifdef CTRL_ILLEGAL_OP_EN
  localparam int W = 13;
`else
  localparam int W = 12;
`endif

  logic       Clk;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Stall;
  logic       Flush;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic       Jump;
  logic [1:0] ALUOp;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       IllegalOp;
`endif

  mips_control_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Opcode   (Opcode),
    .Stall    (Stall),
    .Flush    (Flush),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .Jump     (Jump),
    .ALUOp    (ALUOp)
`ifdef CTRL_ILLEGAL_OP_EN
    ,
    .IllegalOp(IllegalOp)
`endif
  );

  // Observed word: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
  // Branch, Jump, ALUOp[, IllegalOp]
  logic [W-1:0] obs;
`ifdef CTRL_ILLEGAL_OP_EN
  assign obs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                Branch, Jump, ALUOp, IllegalOp};
`else
  assign obs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                Branch, Jump, ALUOp};
`endif

  localparam logic [W-1:0] ZERO = '0;

  int unsigned  n_checks = 0;
  int unsigned  n_fails  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference decode table, transcribed row by row.
  function automatic logic [W-1:0] ref_ctrl(input logic [5:0] op);
    logic [11:0] b;
    logic        ill;
    ill = 1'b0;
    case (op)
      6'b000000: b = 12'b01_0_00_1_0_0_0_0_10;
      6'b000010: b = 12'b00_0_00_0_0_0_0_1_00;
      6'b000011: b = 12'b10_0_10_1_0_0_0_1_00;
      6'b000100: b = 12'b00_0_00_0_0_0_1_0_01;
      6'b001000: b = 12'b00_1_00_1_0_0_0_0_00;
      6'b001010: b = 12'b00_1_00_1_0_0_0_0_01;
      6'b100011: b = 12'b00_1_01_1_1_0_0_0_00;
      6'b101011: b = 12'b00_1_00_0_0_1_0_0_00;
      default: begin
        b   = 12'b0;
        ill = 1'b1;
      end
    endcase
`ifdef CTRL_ILLEGAL_OP_EN
    return {b, ill};
`else
    if (ill) b = 12'b0;
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // Drive one opcode and record what the outputs must show after the next edge.
  task automatic step(input logic [5:0] op, input logic st, input logic fl,
                      input string tag);
    logic [W-1:0] e;
    @(negedge Clk);
    Opcode = op;
    Stall  = st;
    Flush  = fl;
    if (fl)      e = ZERO;
    else if (st) e = last_exp;
    else         e = ref_ctrl(op);
    exp_q.push_back(e);
    last_exp = e;
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  initial begin
    Reset    = 1'b0;
    Opcode   = 6'b100011;
    Stall    = 1'b0;
    Flush    = 1'b0;
    last_exp = ZERO;

    // Asynchronous reset before any clock edge.
    #2 Reset = 1'b1;
    #1 check("reset_async", obs, ZERO);
    @(posedge Clk);
    #1 check("reset_hold", obs, ZERO);

    // Release reset; the first edge loads lw.
    Reset = 1'b0;
    step(6'b100011, 1'b0, 1'b0, "lw_after_reset");

    // Full table, one opcode per cycle.
    step(6'b000000, 1'b0, 1'b0, "rtype");
    step(6'b000010, 1'b0, 1'b0, "j");
    step(6'b000011, 1'b0, 1'b0, "jal");
    n_checks++;
    assert (RegDst === 2'b10 && MemtoReg === 2'b10 && Jump === 1'b1) else begin
      n_fails++;
      $error("FAIL jal_fields: observed RegDst=%b MemtoReg=%b Jump=%b expected 10 10 1",
             RegDst, MemtoReg, Jump);
    end
    step(6'b000100, 1'b0, 1'b0, "beq");
    step(6'b100011, 1'b0, 1'b0, "lw");
    step(6'b101011, 1'b0, 1'b0, "sw");
    step(6'b001000, 1'b0, 1'b0, "addi");
    step(6'b001010, 1'b0, 1'b0, "subi");
    n_checks++;
    assert (ALUOp === 2'b01 && ALUSrc === 1'b1) else begin
      n_fails++;
      $error("FAIL subi_fields: observed ALUOp=%b ALUSrc=%b expected 01 1", ALUOp, ALUSrc);
    end

    // Undefined opcodes decode as NOP (IllegalOp set when the feature is present).
    step(6'b111111, 1'b0, 1'b0, "illegal_111111");
    step(6'b000001, 1'b0, 1'b0, "illegal_000001");
    step(6'b000000, 1'b0, 1'b0, "rtype_after_illegal");

    // Stall holds the latched sw even though the opcode changes.
    step(6'b101011, 1'b0, 1'b0, "sw_latch");
    step(6'b000011, 1'b1, 1'b0, "stall_hold_1");
    step(6'b000100, 1'b1, 1'b0, "stall_hold_2");
    step(6'b000011, 1'b0, 1'b0, "jal_after_stall");

    // Flush beats Stall.
    step(6'b000000, 1'b1, 1'b1, "flush_over_stall");
    step(6'b001000, 1'b0, 1'b0, "addi_after_flush");

    // Stall holds an illegal decode; then Flush clears it.
    step(6'b110000, 1'b0, 1'b0, "illegal_latch");
    step(6'b000000, 1'b1, 1'b0, "illegal_stall_hold");
    step(6'b000000, 1'b0, 1'b1, "illegal_flush");

    // Asynchronous reset mid-cycle while addi is latched.
    step(6'b001000, 1'b0, 1'b0, "addi_pre_reset");
    #2 Reset = 1'b1;
    #1 check("reset_mid_cycle", obs, ZERO);
    exp_q.delete();
    last_exp = ZERO;
    @(posedge Clk);
    #1 check("reset_mid_hold", obs, ZERO);
    Reset = 1'b0;
    step(6'b000100, 1'b0, 1'b0, "beq_after_reset");
    step(6'b100011, 1'b0, 1'b0, "lw_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
- Main decoder of the single-issue MIPS-subset datapath.
- Decodes the 6-bit instruction opcode into the datapath control signals: register-destination select, ALU source, write-back select, register/memory enables, branch, jump and ALU operation class.
- All control outputs are registered, so they align with the next pipeline stage.
- Supports stall (hold) and flush (bubble) from the hazard logic.

Parameters:
- None. Opcode width is fixed at 6 bits.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears all registered outputs
- Opcode  input  6  instruction bits [31:26]
- Stall  input  1  hold all outputs at their current values
- Flush  input  1  load the all-zero bubble on the next edge
- RegDst  output  2  00 = rt, 01 = rd, 10 = $31
- ALUSrc  output  1  0 = register operand, 1 = sign-extended immediate
- MemtoReg  output  2  00 = ALU result, 01 = memory data, 10 = PC+4
- RegWrite  output  1  register file write enable
- MemRead  output  1  data memory read enable
- MemWrite  output  1  data memory write enable
- Branch  output  1  conditional branch (beq)
- Jump  output  1  unconditional jump
- ALUOp  output  2  00 = add, 01 = subtract, 10 = use funct field
- IllegalOp  output  1  present only with CTRL_ILLEGAL_OP_EN

Behaviour:
- One clock. Reset is asynchronous and active-high; the clock and reset ports are named Clk and Reset.
- Reset asserted: every output goes to 0 immediately, independent of Clk, and stays 0 while Reset is high.
- Decode is combinational. The result is registered on the rising edge of Clk, giving one cycle of latency from Opcode to outputs.
- Decode table (fields in order RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp):
  - 000000 R-type: 01, 0, 00, 1, 0, 0, 0, 0, 10
  - 000010 j: 00, 0, 00, 0, 0, 0, 0, 1, 00
  - 000011 jal: 10, 0, 10, 1, 0, 0, 0, 1, 00
  - 000100 beq: 00, 0, 00, 0, 0, 0, 1, 0, 01
  - 001000 addi: 00, 1, 00, 1, 0, 0, 0, 0, 00
  - 001010 subi: 00, 1, 00, 1, 0, 0, 0, 0, 01
  - 100011 lw: 00, 1, 01, 1, 1, 0, 0, 0, 00
  - 101011 sw: 00, 1, 00, 0, 0, 1, 0, 0, 00
  - Any other opcode: all outputs 0 (NOP). No register or memory write ever occurs for an undefined opcode.
- Update priority at each rising edge:
  - Reset beats Flush.
  - Flush beats Stall.
  - Stall beats the normal decode load.
- Flush=1: the registered outputs load all zeros.
- Stall=1 with Flush=0: the registered outputs keep their previous values; the Opcode input is ignored.
- Reset deasserted mid-stream: the first edge after deassertion loads the decode of the Opcode present at that edge.
- Invariant: MemRead and MemWrite are never both 1.
- Invariant: Branch and Jump are never both 1.

Optional Feature:
- Macro CTRL_ILLEGAL_OP_EN.
- Defined:
  - Adds the registered output IllegalOp.
  - IllegalOp is 1 when the latched opcode is not in the decode table; all other outputs still read 0 in that case.
  - IllegalOp is cleared by Reset and by Flush, and held by Stall.
- Not defined:
  - The port does not exist.
  - Undefined opcodes silently decode as NOP.

Test Plan:
- Reset=1 with Opcode=100011 -> all outputs 0, with no clock edge required. Release Reset, one edge -> lw pattern: RegDst 00, ALUSrc 1, MemtoReg 01, RegWrite 1, MemRead 1.
- Apply R-type, j, jal, beq, lw, sw, addi, subi, one per cycle -> each output matches its table row exactly one cycle later. Spot checks:
  - jal: RegDst 10, MemtoReg 10, Jump 1.
  - subi: ALUOp 01, ALUSrc 1.
- Opcode=111111 -> all outputs 0. With CTRL_ILLEGAL_OP_EN, IllegalOp=1. Then Opcode=000000 -> IllegalOp=0 and R-type row.
- Latch sw, then Stall=1 while Opcode changes to 000011 -> outputs stay MemWrite 1, ALUSrc 1. Deassert Stall -> jal row on the next edge.
- Opcode=000000 with Stall=1 and Flush=1 together -> all outputs 0 (flush wins).
- Assert Reset asynchronously mid-cycle while the addi row is latched -> outputs go to 0 before the next Clk edge.
